// File: rtl/generals_pkg.sv
// Shared types for the Generals match sequencer: scheduler states and player ids.
package generals_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PICK,
    GROWTH,
    TURN,
    OVER
  } sched_state_t;

  localparam int PLAYER_ID_W = 3;
  typedef logic [PLAYER_ID_W-1:0] player_id_t;

  localparam player_id_t PLAYER_NONE = '0;

endpackage

// File: rtl/next_alive_finder.sv
// Combinational search for the first alive player strictly after `origin`, wrapping,
// plus a wrap flag and a count of living players.
module next_alive_finder #(
  parameter int N    = 7,
  parameter int ID_W = 3
) (
  input  logic [N-1:0]    alive,
  input  logic [ID_W-1:0] origin,
  output logic [ID_W-1:0] found,
  output logic            wrapped,
  output logic [ID_W-1:0] count
);

  localparam logic [ID_W:0] N_EXT = (ID_W + 1)'(N);

  logic [N-1:0]    rotated;
  logic [ID_W-1:0] offset;
  logic            any;
  logic [ID_W:0]   sum;
  logic [ID_W:0]   id_ext;

  // Bit j of rotated is the player (origin + j) mod N + 1.
  assign rotated = N'({alive, alive} >> origin);

  always_comb begin
    offset = '0;
    any    = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rotated[j]) begin
        offset = ID_W'(j);
        any    = 1'b1;
      end
    end
  end

  assign sum    = {1'b0, origin} + {1'b0, offset} + 1'b1;
  assign id_ext = (sum > N_EXT) ? (sum - N_EXT) : sum;
  assign found  = any ? id_ext[ID_W-1:0] : '0;
  assign wrapped = any && (found <= origin);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + ID_W'(alive[i]);
    end
  end

endmodule

// File: rtl/turn_scheduler.sv
// Turn sequencer for a Generals match: picks the next living player, times each
// turn, counts rounds and requests a growth sweep at every round wrap.
module turn_scheduler
  import generals_pkg::*;
#(
  parameter int MAX_PLAYER_CNT      = 7,
  parameter int LOG2_MAX_PLAYER_CNT = 3,
  parameter int LOG2_MAX_ROUND      = 12,
  parameter int TURN_TICKS          = 500_000_000,
  parameter int TIMER_WIDTH         = 29,
  parameter int GROWTH_PERIOD       = 25
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [MAX_PLAYER_CNT-1:0]      alive,
  input  logic                           move_done,
  input  logic                           growth_ack,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] current_player,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] next_player,
  output logic                           turn_active,
  output logic [LOG2_MAX_ROUND-1:0]      round,
  output logic [TIMER_WIDTH-1:0]         time_left,
  output logic                           growth_req,
  output logic                           growth_all,
  output logic                           game_over,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] winner
);

  localparam int                    ID_W       = LOG2_MAX_PLAYER_CNT;
  localparam logic [ID_W-1:0]       ID_NONE    = ID_W'(PLAYER_NONE);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LOAD = TIMER_WIDTH'(TURN_TICKS - 1);

  sched_state_t                state_reg, state_next;
  logic [LOG2_MAX_ROUND-1:0]   round_reg, round_next, round_inc;
  logic [ID_W-1:0]             origin_reg, origin_next;
  logic [ID_W-1:0]             current_reg, current_next;
  logic [ID_W-1:0]             pending_reg, pending_next;
  logic [ID_W-1:0]             winner_reg, winner_next;
  logic [ID_W-1:0]             next_reg;
  logic [TIMER_WIDTH-1:0]      timer_reg, timer_next;
  logic                        growth_req_reg, growth_req_next;
  logic                        growth_all_reg, growth_all_next;

  logic [ID_W-1:0]             pick_found, pick_count, next_found, next_count;
  logic                        pick_wrapped, next_wrapped, next_unused;
  logic [MAX_PLAYER_CNT-1:0]   cur_hit;
  logic                        cur_alive;

  next_alive_finder #(.N(MAX_PLAYER_CNT), .ID_W(ID_W)) pick_finder (
    .alive   (alive),
    .origin  (origin_reg),
    .found   (pick_found),
    .wrapped (pick_wrapped),
    .count   (pick_count)
  );

  next_alive_finder #(.N(MAX_PLAYER_CNT), .ID_W(ID_W)) peek_finder (
    .alive   (alive),
    .origin  (current_reg),
    .found   (next_found),
    .wrapped (next_wrapped),
    .count   (next_count)
  );

  assign next_unused = ^{next_wrapped, next_count};

  genvar gi;
  generate
    for (gi = 0; gi < MAX_PLAYER_CNT; gi++) begin : g_cur_hit
      assign cur_hit[gi] = alive[gi] && (current_reg == ID_W'(gi + 1));
    end
  endgenerate
  assign cur_alive = |cur_hit;

  assign round_inc = (round_reg == '1) ? round_reg : round_reg + 1'b1;

  always_comb begin
    state_next      = state_reg;
    round_next      = round_reg;
    origin_next     = origin_reg;
    current_next    = current_reg;
    pending_next    = pending_reg;
    winner_next     = winner_reg;
    timer_next      = timer_reg;
    growth_req_next = growth_req_reg;
    growth_all_next = growth_all_reg;
    case (state_reg)
      IDLE, OVER: begin
        if (start) begin
          state_next   = PICK;
          round_next   = LOG2_MAX_ROUND'(1);
          origin_next  = ID_NONE;
          current_next = ID_NONE;
          winner_next  = ID_NONE;
        end
      end
      PICK: begin
        if (pick_count <= ID_W'(1)) begin
          state_next   = OVER;
          winner_next  = (pick_count == ID_W'(1)) ? pick_found : ID_NONE;
          current_next = ID_NONE;
        end else if (pick_wrapped && origin_reg != ID_NONE) begin
          state_next      = GROWTH;
          round_next      = round_inc;
          pending_next    = pick_found;
          growth_req_next = 1'b1;
          growth_all_next = (int'(round_inc) % GROWTH_PERIOD) == 0;
        end else begin
          state_next   = TURN;
          current_next = pick_found;
          timer_next   = TIMER_LOAD;
        end
      end
      GROWTH: begin
        if (growth_ack) begin
          state_next      = TURN;
          growth_req_next = 1'b0;
          growth_all_next = 1'b0;
          current_next    = pending_reg;
          timer_next      = TIMER_LOAD;
        end
      end
      TURN: begin
        // Any combination of end events collapses into a single advance.
        if (move_done || timer_reg == '0 || !cur_alive) begin
          state_next   = PICK;
          origin_next  = current_reg;
          current_next = ID_NONE;
          timer_next   = '0;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      round_reg      <= '0;
      origin_reg     <= '0;
      current_reg    <= '0;
      pending_reg    <= '0;
      winner_reg     <= '0;
      next_reg       <= '0;
      timer_reg      <= '0;
      growth_req_reg <= 1'b0;
      growth_all_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      round_reg      <= round_next;
      origin_reg     <= origin_next;
      current_reg    <= current_next;
      pending_reg    <= pending_next;
      winner_reg     <= winner_next;
      next_reg       <= next_found;
      timer_reg      <= timer_next;
      growth_req_reg <= growth_req_next;
      growth_all_reg <= growth_all_next;
    end
  end

  assign current_player = current_reg;
  assign next_player    = next_reg;
  assign turn_active    = (state_reg == TURN);
  assign round          = round_reg;
  assign time_left      = timer_reg;
  assign growth_req     = growth_req_reg;
  assign growth_all     = growth_all_reg;
  assign game_over      = (state_reg == OVER);
  assign winner         = winner_reg;

endmodule
